// File: rtl/cpu_net_if.sv
// Memory-side bus of the cpu_net accumulator core: instruction in, address/store data/strobe out.
interface cpu_net_if;
   logic [7:0] inst;
   logic [7:0] address;
   logic [7:0] out_data;
   logic       store;

   modport master (
      input  inst,
      output address,
      output out_data,
      output store
   );

   modport slave (
      output inst,
      input  address,
      input  out_data,
      input  store
   );
endinterface

// File: rtl/cpu_net.sv
// 8-bit accumulator core executing one externally supplied instruction per clock.
// Every state bit is reset so the core is fully deterministic from reset.
module cpu_net (
   input  logic      clk,
   input  logic      reset,
   cpu_net_if.master bus
);
   typedef enum logic [2:0] {
      OP_LDI   = 3'd0,
      OP_ADDI  = 3'd1,
      OP_ADD   = 3'd2,
      OP_SUB   = 3'd3,
      OP_LOG   = 3'd4,
      OP_MOV   = 3'd5,
      OP_STORE = 3'd6,
      OP_SHJZ  = 3'd7
   } opcode_e;

   logic [7:0]      acc_q, acc_d;
   logic [7:0]      pc_q, pc_d;
   logic [3:0][7:0] r_q, r_d;
   logic            z_q, z_d;
   logic            c_q, c_d;
   logic [7:0]      address_q, address_d;
   logic [7:0]      out_data_q, out_data_d;
   logic            store_q, store_d;

   opcode_e    op;
   logic [1:0] n;
   logic [1:0] sub_op;
   logic [7:0] imm5;
   logic [7:0] rn;
   logic [8:0] sum9;
   logic       acc_wr;

   assign op     = opcode_e'(bus.inst[7:5]);
   assign n      = bus.inst[1:0];
   assign sub_op = bus.inst[4:3];
   assign imm5   = {3'b000, bus.inst[4:0]};
   assign rn     = r_q[n];

   always_comb begin
      acc_d      = acc_q;
      pc_d       = pc_q + 8'd1;
      r_d        = r_q;
      z_d        = z_q;
      c_d        = c_q;
      out_data_d = out_data_q;
      store_d    = 1'b0;
      acc_wr     = 1'b0;
      sum9       = 9'd0;
      unique case (op)
         OP_LDI: begin
            acc_d  = imm5;
            acc_wr = 1'b1;
         end
         OP_ADDI: begin
            sum9         = {1'b0, acc_q} + {1'b0, imm5};
            {c_d, acc_d} = sum9;
            acc_wr       = 1'b1;
         end
         OP_ADD: begin
            sum9         = {1'b0, acc_q} + {1'b0, rn};
            {c_d, acc_d} = sum9;
            acc_wr       = 1'b1;
         end
         OP_SUB: begin
            acc_d  = acc_q - rn;
            c_d    = (acc_q < rn);
            acc_wr = 1'b1;
         end
         OP_LOG: begin
            unique case (sub_op)
               2'b00:   acc_d = acc_q & rn;
               2'b01:   acc_d = acc_q | rn;
               2'b10:   acc_d = acc_q ^ rn;
               default: acc_d = ~acc_q;
            endcase
            acc_wr = 1'b1;
         end
         OP_MOV: begin
            if (bus.inst[4]) begin
               acc_d  = rn;
               acc_wr = 1'b1;
            end else begin
               r_d[n] = acc_q;
            end
         end
         OP_STORE: begin
            store_d    = 1'b1;
            out_data_d = acc_q;
         end
         default: begin
            unique case (sub_op)
               2'b00: begin
                  c_d    = acc_q[7];
                  acc_d  = {acc_q[6:0], 1'b0};
                  acc_wr = 1'b1;
               end
               2'b01: begin
                  c_d    = acc_q[0];
                  acc_d  = {1'b0, acc_q[7:1]};
                  acc_wr = 1'b1;
               end
               2'b10: begin
                  {c_d, acc_d} = {acc_q, c_q};
                  acc_wr       = 1'b1;
               end
               default: begin
                  // JZ target lives in inst[2:0], not the register index.
                  if (z_q) pc_d = {5'b00000, bus.inst[2:0]};
               end
            endcase
         end
      endcase
      if (acc_wr) z_d = (acc_d == 8'd0);
      address_d = (op == OP_STORE) ? rn : pc_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q      <= 8'd0;
         pc_q       <= 8'd0;
         r_q        <= '0;
         z_q        <= 1'b0;
         c_q        <= 1'b0;
         address_q  <= 8'd0;
         out_data_q <= 8'd0;
         store_q    <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         pc_q       <= pc_d;
         r_q        <= r_d;
         z_q        <= z_d;
         c_q        <= c_d;
         address_q  <= address_d;
         out_data_q <= out_data_d;
         store_q    <= store_d;
      end
   end

   assign bus.address  = address_q;
   assign bus.out_data = out_data_q;
   assign bus.store    = store_q;
endmodule

// File: tb/tb_cpu_net.sv
// Bench for cpu_net: directed scenarios plus random instruction streams against an integer reference model.
module tb_cpu_net;
   logic clk;
   logic reset;
   cpu_net_if bus ();

   cpu_net dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int errors;

   // Reference architectural state kept as plain integers.
   int m_acc, m_pc, m_z, m_c, m_addr, m_data, m_st;
   int m_r[4];

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic model(input int i, input bit r);
      int op, n, imm, sel, s, old;
      bit wr;
      if (r) begin
         m_acc = 0; m_pc = 0; m_z = 0; m_c = 0;
         m_addr = 0; m_data = 0; m_st = 0;
         for (int k = 0; k < 4; k++) m_r[k] = 0;
         return;
      end
      op  = i / 32;
      n   = i % 4;
      imm = i % 32;
      sel = (i / 8) % 4;
      wr  = 1'b1;
      m_st = 0;
      m_pc = (m_pc + 1) % 256;
      case (op)
         0: m_acc = imm;
         1: begin s = m_acc + imm; m_c = (s > 255); m_acc = s % 256; end
         2: begin s = m_acc + m_r[n]; m_c = (s > 255); m_acc = s % 256; end
         3: begin m_c = (m_acc < m_r[n]); m_acc = (m_acc - m_r[n] + 256) % 256; end
         4: case (sel)
               0: m_acc = m_acc & m_r[n];
               1: m_acc = m_acc | m_r[n];
               2: m_acc = m_acc ^ m_r[n];
               default: m_acc = 255 - m_acc;
            endcase
         5: if (imm >= 16) m_acc = m_r[n];
            else begin m_r[n] = m_acc; wr = 1'b0; end
         6: begin m_st = 1; m_data = m_acc; wr = 1'b0; end
         default: begin
            old = m_acc;
            case (sel)
               0: begin m_c = (old >= 128); m_acc = (old * 2) % 256; end
               1: begin m_c = old % 2; m_acc = old / 2; end
               2: begin m_acc = (old * 2) % 256 + m_c; m_c = (old >= 128); end
               default: begin
                  wr = 1'b0;
                  if (m_z != 0) m_pc = i % 8;
               end
            endcase
         end
      endcase
      if (wr) m_z = (m_acc == 0);
      m_addr = (op == 6) ? m_r[n] : m_pc;
   endtask

   task automatic step(input logic [7:0] i, input logic r);
      @(negedge clk);
      bus.inst = i;
      reset    = r;
      @(posedge clk);
      model(int'(i), r);
      #1;
      check("address",  int'(bus.address),  m_addr);
      check("out_data", int'(bus.out_data), m_data);
      check("store",    int'(bus.store),    m_st);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      reset    = 1'b1;
      bus.inst = 8'h00;
      model(0, 1'b1);

      // Reset state
      step(8'hC0, 1'b1);
      check("rst_addr", int'(bus.address), 0);
      check("rst_store", int'(bus.store), 0);

      // LDI 0 three times: PC walks 1,2,3
      for (int k = 0; k < 3; k++) step(8'h00, 1'b0);
      check("t1_addr", int'(bus.address), 3);

      // ACC=15 via ADDI, move to R0, store through R0
      step(8'h00, 1'b1);
      for (int k = 0; k < 5; k++) step(8'h23, 1'b0);
      step(8'hA0, 1'b0);
      step(8'hC0, 1'b0);
      check("t2_addr", int'(bus.address), 8'h0F);
      check("t2_data", int'(bus.out_data), 8'h0F);
      check("t2_store", int'(bus.store), 1);
      step(8'h00, 1'b0);
      check("t2_next_addr", int'(bus.address), 8);
      check("t2_next_store", int'(bus.store), 0);

      // JZ taken then not taken
      step(8'h00, 1'b1);
      step(8'h00, 1'b0);
      step(8'hFB, 1'b0);
      check("t3_jz_taken", int'(bus.address), 3);
      step(8'h01, 1'b0);
      step(8'hFB, 1'b0);
      check("t3_jz_not", int'(bus.address), 5);

      // SUB borrow, then ADD clears carry; carry exposed via ROL and STORE
      step(8'h00, 1'b1);
      step(8'h07, 1'b0);
      step(8'hA1, 1'b0);
      step(8'h05, 1'b0);
      step(8'h61, 1'b0);
      step(8'hA2, 1'b0);
      step(8'hC2, 1'b0);
      check("t4_addr", int'(bus.address), 8'hFE);
      check("t4_data", int'(bus.out_data), 8'hFE);
      step(8'h00, 1'b0);
      step(8'h47, 1'b0);
      step(8'hF0, 1'b0);
      step(8'hA0, 1'b0);
      step(8'hC0, 1'b0);
      check("t4_carry_cleared", int'(bus.out_data), 0);

      // PC wrap after 256 cycles
      step(8'h00, 1'b1);
      for (int k = 0; k < 256; k++) step(8'h00, 1'b0);
      check("t5_wrap", int'(bus.address), 0);

      // Reset overrides a STORE
      step(8'h1F, 1'b0);
      step(8'hA3, 1'b0);
      step(8'hC3, 1'b0);
      step(8'hC3, 1'b1);
      check("t6_addr", int'(bus.address), 0);
      check("t6_data", int'(bus.out_data), 0);
      check("t6_store", int'(bus.store), 0);

      // Random instruction streams with occasional reset
      for (int k = 0; k < 1500; k++) begin
         step(8'($urandom_range(0, 255)), ($urandom_range(0, 63) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
